// File: rtl/wb_arbiter.sv
// Round-robin scheduler sharing the single register-file writeback port among NREQ units.
// Optional per-unit grant and conflict counters are compiled in when WB_ARB_PERF_EN is defined.
module wb_arbiter #(
    parameter int NREQ   = 4,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*REG_W-1:0]   req_reg,
    input  logic [NREQ*DATA_W-1:0]  req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    freeze,
    input  logic                    flush,
    output logic                    wb_en,
    output logic [REG_W-1:0]        wb_reg,
    output logic [DATA_W-1:0]       wb_data,
    output logic [$clog2(NREQ)-1:0] wb_src
`ifdef WB_ARB_PERF_EN
    ,
    output logic [NREQ*16-1:0]      perf_grants,
    output logic [15:0]             perf_conflicts
`endif
);

    localparam int SRC_W = $clog2(NREQ);

    logic [SRC_W-1:0]  r_ptr;
    logic              r_wbEn;
    logic [REG_W-1:0]  r_wbReg;
    logic [DATA_W-1:0] r_wbData;
    logic [SRC_W-1:0]  r_wbSrc;

    logic              w_found;
    logic [SRC_W-1:0]  w_grantIdx;
    logic              w_blocked;
    logic              w_handshake;

    // Both operands are below NREQ, so a single conditional subtract wraps correctly.
    function automatic logic [SRC_W-1:0] wrapIdx(input logic [SRC_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return SRC_W'(s);
    endfunction

    always_comb begin
        w_found    = 1'b0;
        w_grantIdx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[wrapIdx(r_ptr, k)]) begin
                w_found    = 1'b1;
                w_grantIdx = wrapIdx(r_ptr, k);
            end
        end
    end

    assign w_blocked   = !nRST || freeze || flush;
    assign w_handshake = w_found && !w_blocked;
    assign req_ready   = w_handshake ? (NREQ'(1) << w_grantIdx) : '0;

    // Flush wins over freeze; freeze keeps wb_en high because the consumer is stalled.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ptr    <= '0;
            r_wbEn   <= 1'b0;
            r_wbReg  <= '0;
            r_wbData <= '0;
            r_wbSrc  <= '0;
        end else if (flush) begin
            r_wbEn <= 1'b0;
        end else if (freeze) begin
            r_wbEn <= r_wbEn;
        end else if (w_handshake) begin
            r_wbEn   <= 1'b1;
            r_wbReg  <= req_reg[w_grantIdx*REG_W +: REG_W];
            r_wbData <= req_data[w_grantIdx*DATA_W +: DATA_W];
            r_wbSrc  <= w_grantIdx;
            r_ptr    <= wrapIdx(w_grantIdx, 1);
        end else begin
            r_wbEn <= 1'b0;
        end
    end

    assign wb_en   = r_wbEn;
    assign wb_reg  = r_wbReg;
    assign wb_data = r_wbData;
    assign wb_src  = r_wbSrc;

`ifdef WB_ARB_PERF_EN
    logic [15:0] r_perfGrants [NREQ];
    logic [15:0] r_perfConflicts;

    // Counters only advance on a real handshake, which already excludes freeze and flush.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREQ; i++) begin
                r_perfGrants[i] <= '0;
            end
            r_perfConflicts <= '0;
        end else if (w_handshake) begin
            if (r_perfGrants[w_grantIdx] != 16'hFFFF) begin
                r_perfGrants[w_grantIdx] <= r_perfGrants[w_grantIdx] + 16'd1;
            end
            if (($countones(req_valid) >= 2) && (r_perfConflicts != 16'hFFFF)) begin
                r_perfConflicts <= r_perfConflicts + 16'd1;
            end
        end
    end

    always_comb begin
        perf_grants = '0;
        for (int i = 0; i < NREQ; i++) begin
            perf_grants[i*16 +: 16] = r_perfGrants[i];
        end
    end

    assign perf_conflicts = r_perfConflicts;
`endif

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Round-robin writeback scheduler that shares the single register-file writeback port among NREQ functional units (scalar ALU, matrix load/store, GEMM, …).
- Accepts at most one completion per cycle via a valid/ready handshake.
- Registers the winner onto the wb bus that feeds dispatch (wb_ctr_t source) and the register file.
- Honours freeze (hold) and flush (drop) from pipeline control.

Parameters:
NREQ, 4, number of requesting functional units (≥2)
REG_W, 5, destination register index width
DATA_W, 32, writeback data width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-FU completion valid
req_reg  in  NREQ*REG_W  per-FU destination reg; slice i = [i*REG_W +: REG_W]
req_data  in  NREQ*DATA_W  per-FU result; slice i = [i*DATA_W +: DATA_W]
req_ready  out  NREQ  per-FU grant; handshake completes when valid&ready
freeze  in  1  hold: no grants, wb outputs hold value
flush  in  1  squash: no grants, wb_en cleared next cycle
wb_en  out  1  registered writeback valid
wb_reg  out  REG_W  registered destination reg
wb_data  out  DATA_W  registered result
wb_src  out  $clog2(NREQ)  index of FU that produced current wb

Behaviour:
- Reset (nRST=0, async): wb_en=0, wb_reg=0, wb_data=0, wb_src=0, rr pointer ptr=0.
  - req_ready is combinational and is 0 while in reset.
- Grant (combinational):
  - Search req_valid starting at index ptr, increasing, wrapping mod NREQ.
  - The first valid index g gets req_ready[g]=1; all others get 0.
  - At most one bit of req_ready is set.
  - req_ready[i] never asserts without req_valid[i].
- If freeze=1 or flush=1, req_ready=0 for all requesters. flush takes precedence over freeze when both are asserted.
- Pointer: on a completed handshake, ptr <= (g+1) mod NREQ. Otherwise ptr holds, including under freeze or flush.
- Latency: handshake in cycle N gives wb_en=1, wb_reg=req_reg[g], wb_data=req_data[g], wb_src=g in cycle N+1.
  - wb_en is high for exactly one cycle per handshake unless frozen.
- Idle: no valid, no freeze, no flush → next wb_en=0; wb_reg, wb_data and wb_src hold their old values.
- freeze=1: all wb outputs hold their current values, including wb_en=1 if it was set (the consumer is stalled).
- flush=1: next wb_en=0; wb_reg, wb_data and wb_src hold.
- Fairness: a requester that holds valid continuously is granted within NREQ cycles of non-frozen, non-flushed operation.
- Requesters must hold req_valid, req_reg and req_data stable until the handshake completes. The arbiter does not check this.
- Single valid: granted the same cycle regardless of ptr.
- All valid every cycle: grants cycle 0,1,…,NREQ-1,0,… starting from ptr.
- Back-to-back handshakes from the same FU are allowed when it is the only valid requester.
- Reset asserted mid-operation: in-flight wb dropped (wb_en→0 immediately), ptr→0, no request consumed.

Optional Feature:
WB_ARB_PERF_EN
- Defined: adds outputs perf_grants (NREQ*16, per-FU saturating grant counters) and perf_conflicts (16, saturating count of cycles in which a grant occurred with ≥2 req_valid high).
  - Counters reset to 0 on nRST.
  - Counters saturate at 16'hFFFF.
  - Counters do not increment under freeze or flush.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset: nRST=0 with req_valid=4'b1111 → req_ready=0, wb_en=0, ptr=0. Release; first cycle grants FU0 → next cycle wb_en=1, wb_src=0.
2. Round robin: req_valid=4'b1111 held for 8 cycles, distinct req_reg/data per FU → wb_src sequence 0,1,2,3,0,1,2,3 with matching wb_reg/wb_data, one cycle after each req_ready.
3. Sparse: only FU2 valid, ptr=3 → req_ready=4'b0100 same cycle; next cycle wb_reg=req_reg[2], ptr=3. Then FU1 and FU3 valid → FU3 granted first.
4. Freeze: wb_en=1, data=32'hDEADBEEF, freeze=1 for 3 cycles with FU1 valid → req_ready=0, outputs hold DEADBEEF, ptr unchanged. Release → FU1 granted.
5. Flush: handshake with FU0 then flush=1 next cycle → wb_en shows FU0 result once, then 0. flush+freeze together → wb_en=0, no grant.
6. (WB_ARB_PERF_EN) 10 cycles all-valid → perf_grants FU0..3 = 3,3,2,2 (ptr=0 start), perf_conflicts=10. Force saturation → holds 16'hFFFF.
